sweep_ctrl: RTL and testbench

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sweep_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_ctrl.sv
// Frequency sweep sequencer: steps a frequency word from start to stop, dwelling at each point.
// Optional macro SWEEP_BIDIR_EN enables descending sweeps when start > stop.
module sweep_ctrl #(
    parameter int FWORD_WIDTH = 32,
    parameter int DWELL_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   param_wen,
    input  logic [FWORD_WIDTH-1:0] sweep_start_fword,
    input  logic [FWORD_WIDTH-1:0] sweep_stop_fword,
    input  logic [FWORD_WIDTH-1:0] sweep_step_fword,
    input  logic [DWELL_WIDTH-1:0] sweep_dwell,
    input  logic                   sweep_start,
    input  logic                   sweep_abort,
    output logic [FWORD_WIDTH-1:0] sweep_fword,
    output logic                   fword_wen,
    output logic                   point_valid,
    output logic [15:0]            point_idx,
    output logic                   sweep_busy,
    output logic                   sweep_done,
    output logic                   sweep_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [FWORD_WIDTH-1:0] start_buf_q;
    logic [FWORD_WIDTH-1:0] stop_buf_q;
    logic [FWORD_WIDTH-1:0] step_buf_q;
    logic [DWELL_WIDTH-1:0] dwell_buf_q;
    logic [DWELL_WIDTH-1:0] cnt_q;
    logic                   dir_down_q;
    logic [FWORD_WIDTH-1:0] fword_q;
    logic                   fwen_q;
    logic                   valid_q;
    logic [15:0]            idx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic [FWORD_WIDTH:0]   sum_up;
    logic [FWORD_WIDTH:0]   diff_dn;
    logic [DWELL_WIDTH-1:0] dwell_lim;
    logic                   last_pt_d;
    logic [FWORD_WIDTH-1:0] next_fword_d;
    logic                   start_down_d;
    logic                   start_reject_d;

    function automatic logic last_up(input logic [FWORD_WIDTH:0]   nxt,
                                     input logic [FWORD_WIDTH-1:0] cur,
                                     input logic [FWORD_WIDTH-1:0] stop,
                                     input logic [FWORD_WIDTH-1:0] step);
        return nxt[FWORD_WIDTH] || (nxt[FWORD_WIDTH-1:0] > stop) ||
               (cur == stop) || (step == '0);
    endfunction

    function automatic logic last_dn(input logic [FWORD_WIDTH:0]   nxt,
                                     input logic [FWORD_WIDTH-1:0] cur,
                                     input logic [FWORD_WIDTH-1:0] stop,
                                     input logic [FWORD_WIDTH-1:0] step);
        return nxt[FWORD_WIDTH] || (nxt[FWORD_WIDTH-1:0] < stop) ||
               (cur == stop) || (step == '0);
    endfunction

    // One extra bit so the carry/borrow of the step is visible to the last-point test.
    assign sum_up  = {1'b0, fword_q} + {1'b0, step_buf_q};
    assign diff_dn = {1'b0, fword_q} - {1'b0, step_buf_q};

    assign dwell_lim = (dwell_buf_q == '0) ? '0 : dwell_buf_q - DWELL_WIDTH'(1);

    assign last_pt_d    = dir_down_q ? last_dn(diff_dn, fword_q, stop_buf_q, step_buf_q)
                                     : last_up(sum_up, fword_q, stop_buf_q, step_buf_q);
    assign next_fword_d = dir_down_q ? diff_dn[FWORD_WIDTH-1:0] : sum_up[FWORD_WIDTH-1:0];

`ifdef SWEEP_BIDIR_EN
    assign start_down_d   = (start_buf_q > stop_buf_q);
    assign start_reject_d = 1'b0;
`else
    assign start_down_d   = 1'b0;
    assign start_reject_d = (start_buf_q > stop_buf_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_buf_q <= '0;
            stop_buf_q  <= '0;
            step_buf_q  <= '0;
            dwell_buf_q <= '0;
            cnt_q       <= '0;
            dir_down_q  <= 1'b0;
            fword_q     <= '0;
            fwen_q      <= 1'b0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            fwen_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            if ((state_q == IDLE) && param_wen) begin
                start_buf_q <= sweep_start_fword;
                stop_buf_q  <= sweep_stop_fword;
                step_buf_q  <= sweep_step_fword;
                dwell_buf_q <= sweep_dwell;
            end

            // Abort overrides every state, including a simultaneous start in IDLE.
            if (sweep_abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sweep_start) begin
                            if (start_reject_d) begin
                                err_q <= 1'b1;
                            end else begin
                                fword_q    <= start_buf_q;
                                fwen_q     <= 1'b1;
                                idx_q      <= '0;
                                cnt_q      <= '0;
                                busy_q     <= 1'b1;
                                dir_down_q <= start_down_d;
                                state_q    <= DWELL;
                            end
                        end
                    end
                    DWELL: begin
                        cnt_q <= cnt_q + DWELL_WIDTH'(1);
                        if (cnt_q == dwell_lim) begin
                            valid_q <= 1'b1;
                            state_q <= STEP;
                        end
                    end
                    STEP: begin
                        if (last_pt_d) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            fword_q <= next_fword_d;
                            fwen_q  <= 1'b1;
                            idx_q   <= idx_q + 16'd1;
                            cnt_q   <= '0;
                            state_q <= DWELL;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sweep_fword = fword_q;
    assign fword_wen   = fwen_q;
    assign point_valid = valid_q;
    assign point_idx   = idx_q;
    assign sweep_busy  = busy_q;
    assign sweep_done  = done_q;
    assign sweep_err   = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed testbench for sweep_ctrl; expected values are hand-derived edge by edge.
`timescale 1ns/1ps
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        param_wen;
    logic [31:0] start_fw, stop_fw, step_fw, dwell;
    logic        sweep_start, sweep_abort;
    logic [31:0] sweep_fword;
    logic        fword_wen, point_valid, sweep_busy, sweep_done, sweep_err;
    logic [15:0] point_idx;

    int n_chk = 0;
    int n_err = 0;

    sweep_ctrl #(.FWORD_WIDTH(32), .DWELL_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .param_wen(param_wen),
        .sweep_start_fword(start_fw), .sweep_stop_fword(stop_fw),
        .sweep_step_fword(step_fw), .sweep_dwell(dwell),
        .sweep_start(sweep_start), .sweep_abort(sweep_abort),
        .sweep_fword(sweep_fword), .fword_wen(fword_wen), .point_valid(point_valid),
        .point_idx(point_idx), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .sweep_err(sweep_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] s, input logic [31:0] sp,
                        input logic [31:0] st, input logic [31:0] d);
        start_fw  = s;
        stop_fw   = sp;
        step_fw   = st;
        dwell     = d;
        param_wen = 1'b1;
        tick();
        param_wen = 1'b0;
    endtask

    task automatic do_start();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
    endtask

    initial begin
        int n_fwen, n_valid, n_done, n_errp, done_e;
        logic saw1300;
        logic [31:0] fw_e2, fw_e4;

        rst = 1'b1; param_wen = 1'b0; sweep_start = 1'b0; sweep_abort = 1'b0;
        start_fw = '0; stop_fw = '0; step_fw = '0; dwell = '0;
        #12;
        chk("rst fword", sweep_fword, 0);
        chk("rst fwen", fword_wen, 0);
        chk("rst valid", point_valid, 0);
        chk("rst idx", point_idx, 0);
        chk("rst busy", sweep_busy, 0);
        chk("rst done", sweep_done, 0);
        chk("rst err", sweep_err, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic ascending sweep, dwell 4
        load(1000, 1300, 100, 4);
        do_start();
        chk("t1 e0 fword", sweep_fword, 1000);
        chk("t1 e0 fwen", fword_wen, 1);
        chk("t1 e0 busy", sweep_busy, 1);
        chk("t1 e0 idx", point_idx, 0);
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("t1 e%0d valid", e), point_valid, (e % 5 == 4) ? 1 : 0);
            chk($sformatf("t1 e%0d fwen", e), fword_wen, (e % 5 == 0 && e < 20) ? 1 : 0);
            chk($sformatf("t1 e%0d fword", e), sweep_fword,
                1000 + 100 * ((e >= 15) ? 3 : e / 5));
            chk($sformatf("t1 e%0d done", e), sweep_done, (e == 20) ? 1 : 0);
            chk($sformatf("t1 e%0d busy", e), sweep_busy, (e < 20) ? 1 : 0);
        end
        chk("t1 final idx", point_idx, 3);
        tick();
        chk("t1 done single pulse", sweep_done, 0);

        // Stop not on grid: 1300 must never appear
        load(1000, 1250, 100, 2);
        do_start();
        n_fwen = 0; n_valid = 0; done_e = -1; saw1300 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            n_fwen  += fword_wen;
            n_valid += point_valid;
            if (sweep_done) done_e = e;
            if (sweep_fword == 1300) saw1300 = 1'b1;
        end
        chk("t2 fwen count", n_fwen, 2);
        chk("t2 valid count", n_valid, 3);
        chk("t2 done edge", done_e, 9);
        chk("t2 final fword", sweep_fword, 1200);
        chk("t2 saw 1300", saw1300, 0);
        chk("t2 final idx", point_idx, 2);

        // Carry out of the step ends the sweep after one point
        load(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 1);
        do_start();
        tick();
        chk("t3 e1 valid", point_valid, 1);
        tick();
        chk("t3 e2 done", sweep_done, 1);
        chk("t3 e2 fword", sweep_fword, 32'hFFFF_FF00);
        chk("t3 e2 fwen", fword_wen, 0);
        chk("t3 e2 busy", sweep_busy, 0);
        tick();

        // Start-while-busy ignored, then abort in second point
        load(1000, 1300, 100, 4);
        do_start();
        tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        chk("t4 busy start idx", point_idx, 0);
        chk("t4 busy start fwen", fword_wen, 0);
        chk("t4 busy start fword", sweep_fword, 1000);
        for (int e = 3; e <= 6; e++) tick();
        chk("t4 e6 fword", sweep_fword, 1100);
        chk("t4 e6 idx", point_idx, 1);
        sweep_abort = 1'b1;
        tick();
        sweep_abort = 1'b0;
        chk("t4 abort busy", sweep_busy, 0);
        chk("t4 abort fword", sweep_fword, 1100);
        chk("t4 abort idx", point_idx, 1);
        n_done = 0; n_valid = 0;
        for (int e = 0; e < 12; e++) begin
            n_done  += sweep_done;
            n_valid += point_valid;
            tick();
        end
        chk("t4 no done", n_done, 0);
        chk("t4 no valid", n_valid, 0);
        load(5000, 5300, 100, 4);
        do_start();
        chk("t4 reload fword", sweep_fword, 5000);
        chk("t4 reload fwen", fword_wen, 1);
        sweep_abort = 1'b1;
        tick();
        sweep_abort = 1'b0;

        // Abort and start together in IDLE: nothing starts
        sweep_abort = 1'b1; sweep_start = 1'b1;
        tick();
        sweep_abort = 1'b0; sweep_start = 1'b0;
        chk("t4b busy", sweep_busy, 0);
        chk("t4b fwen", fword_wen, 0);

        // start > stop
        load(2000, 1000, 500, 1);
        do_start();
`ifdef SWEEP_BIDIR_EN
        chk("t5 e0 fword", sweep_fword, 2000);
        n_errp = sweep_err; done_e = -1; fw_e2 = '0; fw_e4 = '0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_errp += sweep_err;
            if (sweep_done) done_e = e;
            if (e == 2) fw_e2 = sweep_fword;
            if (e == 4) fw_e4 = sweep_fword;
        end
        chk("t5 e2 fword", fw_e2, 1500);
        chk("t5 e4 fword", fw_e4, 1000);
        chk("t5 done edge", done_e, 6);
        chk("t5 err count", n_errp, 0);
`else
        chk("t5 err", sweep_err, 1);
        chk("t5 fwen", fword_wen, 0);
        chk("t5 busy", sweep_busy, 0);
        n_fwen = 0; n_valid = 0; n_errp = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_fwen  += fword_wen;
            n_valid += point_valid;
            n_errp  += sweep_err;
        end
        chk("t5 fwen count", n_fwen, 0);
        chk("t5 valid count", n_valid, 0);
        chk("t5 err single", n_errp, 0);
`endif

        // Asynchronous reset mid-dwell
        load(1000, 1300, 100, 4);
        do_start();
        for (int e = 1; e <= 7; e++) tick();
        chk("t6 pre fword", sweep_fword, 1100);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 rst fword", sweep_fword, 0);
        chk("t6 rst idx", point_idx, 0);
        chk("t6 rst busy", sweep_busy, 0);
        chk("t6 rst done", sweep_done, 0);
        #3;
        rst = 1'b0;
        tick();
        chk("t6 post busy", sweep_busy, 0);
        chk("t6 post done", sweep_done, 0);
        load(1000, 1300, 100, 4);
        do_start();
        chk("t6 restart idx", point_idx, 0);
        chk("t6 restart fword", sweep_fword, 1000);
        chk("t6 restart busy", sweep_busy, 1);
        for (int e = 1; e <= 5; e++) tick();
        chk("t6 e5 idx", point_idx, 1);
        chk("t6 e5 fword", sweep_fword, 1100);
        sweep_abort = 1'b1;
        tick();
        sweep_abort = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
